unsigned_div: RTL

Sequential restoring divider for unsigned integers, the inverse of the unsigned multiplier in the floating-point arithmetic unit. It recovers quotient and remainder from a 2N-bit dividend and an N-bit divisor, one quotient bit per clock. It is the mantissa divide stage of the floating-point divider, and it lets the bench cross-check multiplier products (R / M == Q, remainder 0). Operands are latched on a start handshake and results are held until the next accepted start.

---
 rtl/unsigned_div.sv | 126 ++++++++++++
 1 files changed

// File: rtl/unsigned_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Operands are latched on an accepted start; results hold until the next completion.
module unsigned_div #(
   parameter int unsigned N = 12
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [2*N-1:0]   dividend,
   input  logic [N-1:0]     divisor,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   quotient,
   output logic [N-1:0]     remainder,
   output logic             dbz
);

   localparam int unsigned QW = 2 * N;
   localparam int unsigned CW = $clog2(QW + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  prem_q,  prem_d;
   logic [QW-1:0] sreg_q,  sreg_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [N-1:0]  dvsr_q,  dvsr_d;
   logic [QW-1:0] quot_q,  quot_d;
   logic [N-1:0]  rem_q,   rem_d;
   logic          dbz_q,   dbz_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;

   logic [N:0]    prem_sh;
   logic [N:0]    trial;
   logic [N:0]    prem_nx;
   logic [QW-1:0] sreg_nx;

   // One restoring step; prem stays below the divisor, so bit N of the kept value is always 0.
   always_comb begin
      prem_sh = {prem_q, sreg_q[QW-1]};
      trial   = prem_sh - {1'b0, dvsr_q};
      prem_nx = trial[N] ? prem_sh : trial;
      sreg_nx = {sreg_q[QW-2:0], ~trial[N]};
   end

   always_comb begin
      state_d = state_q;
      prem_d  = prem_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      dvsr_d  = dvsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_RUN: begin
            prem_d = prem_nx[N-1:0];
            sreg_d = sreg_nx;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               quot_d  = sreg_nx;
               rem_d   = prem_nx[N-1:0];
               dbz_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (start) begin
               if (divisor != N'(0)) begin
                  state_d = S_RUN;
                  dvsr_d  = divisor;
                  prem_d  = N'(0);
                  sreg_d  = dividend;
                  cnt_d   = CW'(QW);
               end else begin
                  state_d = S_DONE;
                  quot_d  = {QW{1'b1}};
                  rem_d   = dividend[N-1:0];
                  dbz_d   = 1'b1;
               end
            end
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         prem_q  <= '0;
         sreg_q  <= '0;
         cnt_q   <= '0;
         dvsr_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prem_q  <= prem_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         dvsr_q  <= dvsr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign dbz       = dbz_q;

endmodule
